// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation codes,
// FSM state encoding and the divide-by-zero quotient value.
package md_pkg;

    localparam logic [2:0] MD_NOP   = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    localparam logic [31:0] DIVZERO_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN_MUL = 2'd1,
        ST_RUN_DIV = 2'd2
    } md_state_e;

    // True for the two multiply opcodes.
    function automatic logic md_is_mul(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

    // True for the two divide opcodes.
    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 32x32 multiply and divide. Produces the pending {hi, lo}
// pair: product for MULT/MULTU, {remainder, quotient} for DIV/DIVU.
// Signed division is done on magnitudes with a sign fix-up afterwards.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_ph,
    output logic [31:0] o_pl
);

    logic signed [63:0] w_smul;
    logic [63:0]        w_umul;
    logic               w_signed_div;
    logic [31:0]        w_mag_a;
    logic [31:0]        w_mag_b;
    logic [31:0]        w_dvd;
    logic [31:0]        w_dvs_raw;
    logic [31:0]        w_dvs;
    logic [31:0]        w_q_mag;
    logic [31:0]        w_r_mag;
    logic [31:0]        w_q;
    logic [31:0]        w_r;
    logic               w_div_ovf;

    assign w_smul       = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
    assign w_umul       = {32'd0, i_a} * {32'd0, i_b};

    assign w_signed_div = (i_op == MD_DIV);
    assign w_mag_a      = i_a[31] ? (32'd0 - i_a) : i_a;
    assign w_mag_b      = i_b[31] ? (32'd0 - i_b) : i_b;
    assign w_dvd        = w_signed_div ? w_mag_a : i_a;
    assign w_dvs_raw    = w_signed_div ? w_mag_b : i_b;
    // Divisor forced non-zero so the divider never sees 0; the result is replaced anyway.
    assign w_dvs        = (w_dvs_raw == 32'd0) ? 32'd1 : w_dvs_raw;
    assign w_q_mag      = w_dvd / w_dvs;
    assign w_r_mag      = w_dvd % w_dvs;

    // Quotient negative when operand signs differ; remainder follows the dividend.
    assign w_q = (w_signed_div && (i_a[31] ^ i_b[31])) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r = (w_signed_div && i_a[31])             ? (32'd0 - w_r_mag) : w_r_mag;

    assign w_div_ovf = w_signed_div && (i_a == 32'h8000_0000) && (i_b == 32'hFFFF_FFFF);

    // Select the result pair for the requested operation.
    always_comb begin
        o_ph = 32'd0;
        o_pl = 32'd0;
        case (i_op)
            MD_MULT:  {o_ph, o_pl} = w_smul;
            MD_MULTU: {o_ph, o_pl} = w_umul;
            MD_DIV, MD_DIVU: begin
                if (i_b == 32'd0) begin
                    o_pl = DIVZERO_LO;
                    o_ph = i_a;
                end else if (w_div_ovf) begin
                    o_pl = 32'h8000_0000;
                    o_ph = 32'd0;
                end else begin
                    o_pl = w_q;
                    o_ph = w_r;
                end
            end
            default: begin
                o_ph = 32'd0;
                o_pl = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. The result is computed
// at accept time into a pending pair and committed after a fixed latency,
// while busy/stall hold back younger HI/LO users.
module md_sched
    import md_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    input  logic        hilo_use_e,
    input  logic        rd_sel,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] hilo_rdata
);

    md_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_ph;
    logic [31:0]        r_pl;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic               r_busy;
    logic               r_done;
    logic [31:0]        w_ph;
    logic [31:0]        w_pl;
    logic               w_accept;

    md_arith u_arith (
        .i_op (md_op),
        .i_a  (rs_val),
        .i_b  (rt_val),
        .o_ph (w_ph),
        .o_pl (w_pl)
    );

    assign w_accept = start && !flush;

    // Sequencer FSM: accept, count down, commit or abandon on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ph    <= 32'd0;
            r_pl    <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (md_is_mul(md_op)) begin
                            r_ph    <= w_ph;
                            r_pl    <= w_pl;
                            r_cnt   <= CNT_W'(MUL_LAT - 1);
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN_MUL;
                        end else if (md_is_div(md_op)) begin
                            r_ph    <= w_ph;
                            r_pl    <= w_pl;
                            r_cnt   <= CNT_W'(DIV_LAT - 1);
                            r_busy  <= 1'b1;
                            r_state <= ST_RUN_DIV;
                        end else if (md_op == MD_MTHI) begin
                            r_hi <= rs_val;
                        end else if (md_op == MD_MTLO) begin
                            r_lo <= rs_val;
                        end
                    end
                end
                ST_RUN_MUL, ST_RUN_DIV: begin
                    // The commit edge wins over a simultaneous flush.
                    if (r_cnt == '0) begin
                        r_hi    <= r_ph;
                        r_lo    <= r_pl;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (flush) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign hi         = r_hi;
    assign lo         = r_lo;
    assign stall      = r_busy & hilo_use_e;
    assign hilo_rdata = rd_sel ? r_hi : r_lo;

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: table of md ops checked through a
// scoreboard queue, plus hand sequences for MTHI/MTLO, flush, stray start
// and asynchronous reset.
module tb_md_sched;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        flush;
    logic        hilo_use_e;
    logic        rd_sel;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] hilo_rdata;

    md_sched #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .md_op      (md_op),
        .rs_val     (rs_val),
        .rt_val     (rt_val),
        .flush      (flush),
        .hilo_use_e (hilo_use_e),
        .rd_sel     (rd_sel),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .hilo_rdata (hilo_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        use_e;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          stl;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[15];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [2:0] op);
        return (op == OP_DIV || op == OP_DIVU) ? DIV_LAT : MUL_LAT;
    endfunction

    // Drive one op at a negedge; optionally record its expected commit.
    task automatic launch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic use_e, input bit push,
                          input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        @(negedge clk);
        start      = 1'b1;
        md_op      = op;
        rs_val     = rs;
        rt_val     = rt;
        hilo_use_e = use_e;
        if (push) begin
            e.hi  = ehi;
            e.lo  = elo;
            e.lat = lat_of(op);
            e.stl = use_e ? lat_of(op) : 0;
            sb.push_back(e);
        end
    endtask

    // Wait for done, pop the scoreboard and compare everything observable.
    task automatic drain(input int pre_busy, input int pre_stall, input string tag);
        int   bc;
        int   sc;
        int   i;
        bit   got;
        exp_t e;
        bc  = pre_busy;
        sc  = pre_stall;
        got = 1'b0;
        i   = 0;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        while (!got && i < 40) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy)  bc++;
                if (stall) sc++;
                @(negedge clk);
                i++;
            end
        end
        if (!got) begin
            n_chk++;
            n_err++;
            $display("FAIL %s timeout: no done within 40 cycles", tag);
            if (sb.size() != 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: done with empty scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " hi"}, hi, e.hi);
            chk({tag, " lo"}, lo, e.lo);
            chk({tag, " busy_cycles"}, 32'(bc), 32'(e.lat));
            chk({tag, " stall_cycles"}, 32'(sc), 32'(e.stl));
            rd_sel = 1'b1;
            #1;
            chk({tag, " rdata_hi"}, hilo_rdata, e.hi);
            rd_sel = 1'b0;
            #1;
            chk({tag, " rdata_lo"}, hilo_rdata, e.lo);
            @(negedge clk);
            chk({tag, " done_once"}, {31'd0, done}, 32'd0);
        end
    endtask

    initial begin
        int ndone;
        logic [31:0] hold_hi;
        logic [31:0] hold_lo;

        vecs[0]  = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[1]  = '{OP_DIVU,  32'd100,       32'd0,         1'b1, 32'd100,       32'hFFFF_FFFF};
        vecs[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[3]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h8000_0000};
        vecs[5]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b1, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[6]  = '{OP_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFF, 32'h0000_0003};
        vecs[7]  = '{OP_DIVU,  32'hFFFF_FFFF, 32'd2,         1'b1, 32'h0000_0001, 32'h7FFF_FFFF};
        vecs[8]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,         1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
        vecs[9]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
        vecs[10] = '{OP_MULTU, 32'h8000_0000, 32'd2,         1'b1, 32'h0000_0001, 32'h0000_0000};
        vecs[11] = '{OP_MULT,  32'hFFFF_FFFF, 32'd1,         1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[12] = '{OP_DIVU,  32'hFFFF_FFF9, 32'd2,         1'b1, 32'h0000_0001, 32'h7FFF_FFFC};
        vecs[13] = '{OP_DIV,   32'h8000_0000, 32'd1,         1'b0, 32'h0000_0000, 32'h8000_0000};
        vecs[14] = '{OP_MULT,  32'd6,         32'd7,         1'b1, 32'h0000_0000, 32'h0000_002A};

        reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
        flush = 1'b0; hilo_use_e = 1'b1; rd_sel = 1'b0;

        // Reset state
        #3 reset = 1'b0;
        #10;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Table of md operations
        for (int k = 0; k < 15; k++) begin
            launch(vecs[k].op, vecs[k].rs, vecs[k].rt, vecs[k].use_e, 1'b1, vecs[k].hi, vecs[k].lo);
            drain(0, 0, $sformatf("vec%0d", k));
        end

        // MTHI / MTLO: immediate write, never busy
        launch(OP_MTHI, 32'h1234_5678, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("mthi hi", hi, 32'h1234_5678);
        chk("mthi busy", {31'd0, busy}, 32'd0);
        launch(OP_MTLO, 32'hCAFE_BABE, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        chk("mtlo lo", lo, 32'hCAFE_BABE);
        chk("mtlo hi kept", hi, 32'h1234_5678);
        chk("mtlo busy", {31'd0, busy}, 32'd0);

        // Flush together with start in IDLE drops the op
        launch(OP_MTHI, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_idle mthi", hi, 32'h1234_5678);
        md_op = OP_MULT;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        chk("flush_idle mult busy", {31'd0, busy}, 32'd0);

        // Stray MULT while DIV is in flight is ignored
        launch(OP_DIV, 32'd100, 32'd7, 1'b1, 1'b1, 32'd2, 32'd14);
        @(negedge clk);
        md_op = OP_MULT; rs_val = 32'd6; rt_val = 32'd7;
        chk("stray stall c1", {31'd0, stall}, 32'd1);
        @(negedge clk);
        chk("stray busy c2", {31'd0, busy}, 32'd1);
        drain(2, 2, "stray");

        // Flush mid-DIV in cycle 4: no commit, no done
        hold_hi = hi;
        hold_lo = lo;
        launch(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        repeat (3) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush busy", {31'd0, busy}, 32'd0);
        ndone = 0;
        for (int c = 0; c < 14; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("flush no_done", 32'(ndone), 32'd0);
        chk("flush hi kept", hi, hold_hi);
        chk("flush lo kept", lo, hold_lo);

        // Flush on the commit edge: commit wins
        launch(OP_MULT, 32'd3, 32'd5, 1'b1, 1'b1, 32'd0, 32'd15);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        repeat (4) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_commit done", {31'd0, done}, 32'd1);
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("flush_commit hi", hi, e.hi);
            chk("flush_commit lo", lo, e.lo);
        end else begin
            n_chk++;
            n_err++;
            $display("FAIL flush_commit: scoreboard empty");
        end

        // Asynchronous reset mid-MULT, off the clock edge
        launch(OP_MULT, 32'd9, 32'd9, 1'b1, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst hi", hi, 32'd0);
        chk("async_rst lo", lo, 32'd0);
        chk("async_rst busy", {31'd0, busy}, 32'd0);
        chk("async_rst done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        launch(OP_MULT, 32'd6, 32'd7, 1'b1, 1'b1, 32'd0, 32'd42);
        drain(0, 0, "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
- Multi-cycle multiply/divide sequencer owning the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the E stage and runs the operation over a fixed latency.
- Raises a pipeline stall when a younger instruction needs HI/LO before the result is committed.
- Drives the HI/LO read data that the E-stage MFHI/MFLO path forwards into the EX/MEM register.

Parameters:
- MUL_LAT, 5, cycles from accepted MULT/MULTU to HI/LO commit (>=1)
- DIV_LAT, 10, cycles from accepted DIV/DIVU to HI/LO commit (>=1)
- CNT_W, 4, counter width; must hold max(MUL_LAT, DIV_LAT)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  E-stage op valid; qualifies md_op
- md_op  in  3  1=MULT 2=MULTU 3=DIV 4=DIVU 5=MTHI 6=MTLO; 0/7 = no-op
- rs_val  in  32  operand A / MTHI-MTLO source
- rt_val  in  32  operand B
- flush  in  1  cancel in-flight op (exception/eret)
- hilo_use_e  in  1  E-stage instruction reads or writes HI/LO (MFHI/MFLO/md op)
- rd_sel  in  1  0=LO, 1=HI for hilo_rdata
- busy  out  1  operation in flight
- stall  out  1  freeze F/D/E stages
- done  out  1  one-cycle pulse on HI/LO commit by MULT/MULTU/DIV/DIVU
- hi  out  32  HI register
- lo  out  32  LO register
- hilo_rdata  out  32  combinational rd_sel ? hi : lo

Behaviour:
Reset and accept:
- While reset is low, asynchronously: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0, pending result=0. Any in-flight op is discarded.
- States: IDLE, RUN_MUL, RUN_DIV.
- Accept when state==IDLE, start=1, flush=0. Otherwise start is ignored.

IDLE transitions:
- MULT/MULTU accepted at edge T: compute the 64-bit product into pending {ph,pl}, go to RUN_MUL, load counter=MUL_LAT-1.
- DIV/DIVU accepted at edge T: compute quotient into pl and remainder into ph, go to RUN_DIV, load counter=DIV_LAT-1.
- MTHI/MTLO accepted: write hi (or lo) = rs_val at edge T, stay IDLE, busy stays 0.

RUN_* states:
- Decrement the counter each cycle.
- On the edge where counter==0: hi<=ph, lo<=pl, done=1 for the following cycle, return to IDLE.
- busy=1 exactly LAT cycles, starting the cycle after the accept edge.

Arithmetic:
- MULT/DIV treat operands as signed; MULTU/DIVU as unsigned.
- Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (rt_val==0): lo=32'hFFFF_FFFF, hi=rs_val.
- Signed 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0.

Stall, flush and boundary cases:
- stall = busy & hilo_use_e, combinational. A second md op or MFHI/MFLO waits until commit.
- flush while RUN_*: return to IDLE next edge; hi/lo unchanged; no done pulse.
- flush together with start in IDLE: op dropped.
- flush together with the commit edge: commit wins, done pulses.
- start while busy: ignored. The pipeline guarantees this only occurs under stall.

Decomposition:
- Shared package md_pkg: md_op encodings (MD_MULT..MD_MTLO), state encodings, DIVZERO_LO constant.
- One sub-module, md_arith: combinational signed/unsigned 32x32 multiply and divide with the divide-by-zero and overflow rules; outputs {ph,pl}.
- md_sched holds the FSM, counter, pending registers and HI/LO.

Test Plan:
1. MULT rs=0xFFFF_FFFD (-3), rt=7 -> busy high 5 cycles; then hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; done pulses once.
2. DIVU rs=100, rt=0 -> after 10 cycles lo=0xFFFF_FFFF, hi=100. Then DIV rs=0xFFFF_FFF9 (-7), rt=2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF.
3. MULTU 0xFFFF_FFFF*0xFFFF_FFFF with MFHI (hilo_use_e=1, rd_sel=1) held behind it -> stall high all 5 busy cycles; afterwards hilo_rdata=0xFFFF_FFFE, lo=1.
4. MTHI rs=0x1234_5678 while idle -> hi=0x1234_5678 next cycle, busy never asserts. A second start with MULT during an in-flight DIV -> ignored, DIV result commits.
5. DIV in flight, flush asserted in cycle 4 -> state IDLE next edge; hi/lo keep prior values; no done pulse.
6. reset driven low mid-MULT (cycle 2), asynchronously off-edge -> hi=lo=0, busy=0 immediately. After release, a new MULT 6*7 -> lo=42, hi=0.
